// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module : matrix_pkg
// Brief  : Shared scan-state encoding and default LED matrix geometry/timing.
// Rev    : 1.0  initial release
// ============================================================================
package matrix_pkg;

    localparam int c_ROWS     = 8;
    localparam int c_COLS     = 8;
    localparam int c_TICK_DIV = 200;
    localparam int c_ON_TICKS = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        SHIFT   = 3'd3,
        BLANK   = 3'd4,
        LATCH   = 3'd5,
        DISPLAY = 3'd6
    } scan_state_t;

    // Counter width that stays at least one bit for degenerate sizes
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : matrix_scan_ctrl_if
// Brief  : Frame-buffer read port and column/row driver pins of the scanner.
// Rev    : 1.0  initial release
// ============================================================================
interface matrix_scan_ctrl_if
    import matrix_pkg::*;
#(
    parameter int ROWS = c_ROWS,
    parameter int COLS = c_COLS
);
    logic                    en;
    logic                    rd_en;
    logic [$clog2(ROWS)-1:0] rd_row;
    logic [COLS-1:0]         rd_data;
    logic                    ser_data;
    logic                    ser_clk;
    logic                    ser_latch;
    logic                    oe_n;
    logic [$clog2(ROWS)-1:0] row_sel;
    logic                    frame_done;

    modport master (
        input  en, rd_data,
        output rd_en, rd_row, ser_data, ser_clk, ser_latch, oe_n, row_sel, frame_done
    );

    modport slave (
        output en, rd_data,
        input  rd_en, rd_row, ser_data, ser_clk, ser_latch, oe_n, row_sel, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : scan_tick_gen
// Brief  : Display-tick prescaler; one-cycle tick every DIV clocks after clr.
// Rev    : 1.0  initial release
// ============================================================================
module scan_tick_gen #(
    parameter int DIV = 200
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    output logic      tick
);
    localparam int c_CW = $clog2(DIV);

    logic [c_CW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == c_CW'(DIV - 1));
    assign tick   = w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : matrix_scan_ctrl
// Brief  : LED matrix row-scan scheduler: fetch, shift, blank, latch, display.
// Rev    : 1.0  initial release
// ============================================================================
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int ROWS     = c_ROWS,
    parameter int COLS     = c_COLS,
    parameter int TICK_DIV = c_TICK_DIV,
    parameter int ON_TICKS = c_ON_TICKS
) (
    input  wire logic          clk,
    input  wire logic          rst,
    matrix_scan_ctrl_if.master bus
);
    localparam int c_RW = $clog2(ROWS);
    localparam int c_BW = cw(COLS);
    localparam int c_TW = $clog2(ON_TICKS + 1);

    scan_state_t     r_state;
    scan_state_t     w_next;
    logic [COLS-1:0] r_sreg;
    logic            r_phase;
    logic [c_BW-1:0] r_bit_cnt;
    logic [c_RW-1:0] r_next_row;
    logic [c_RW-1:0] r_row_sel;
    logic [c_TW-1:0] r_tick_cnt;
    logic            r_lit;
    logic            w_tick;
    logic            w_clr;
    logic            w_last_bit;
    logic            w_disp_done;
    logic [c_RW-1:0] w_row_inc;

    assign w_clr       = (r_state == LATCH);
    assign w_last_bit  = r_phase && (r_bit_cnt == c_BW'(COLS - 1));
    assign w_disp_done = w_tick && (r_tick_cnt == c_TW'(ON_TICKS - 1));
    assign w_row_inc   = (r_next_row == c_RW'(ROWS - 1)) ? '0 : r_next_row + c_RW'(1);

    scan_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.en) w_next = FETCH;
            FETCH:   w_next = WAIT;
            WAIT:    w_next = SHIFT;
            SHIFT:   if (w_last_bit) w_next = BLANK;
            BLANK:   w_next = LATCH;
            LATCH:   w_next = DISPLAY;
            DISPLAY: if (w_disp_done) w_next = bus.en ? FETCH : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_lit marks that a row is already latched, so it may stay lit while the next one shifts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg     <= '0;
            r_phase    <= 1'b0;
            r_bit_cnt  <= '0;
            r_next_row <= '0;
            r_row_sel  <= '0;
            r_tick_cnt <= '0;
            r_lit      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_lit <= 1'b0;
                end
                WAIT: begin
                    r_sreg    <= bus.rd_data;
                    r_phase   <= 1'b0;
                    r_bit_cnt <= '0;
                end
                SHIFT: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_sreg    <= r_sreg << 1;
                        r_bit_cnt <= r_bit_cnt + c_BW'(1);
                    end
                end
                LATCH: begin
                    r_row_sel  <= r_next_row;
                    r_next_row <= w_row_inc;
                    r_tick_cnt <= '0;
                    r_lit      <= 1'b1;
                end
                DISPLAY: begin
                    if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + c_TW'(1);
                    end
                    if (w_disp_done && !bus.en) begin
                        r_next_row <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rd_en      = 1'b0;
        bus.rd_row     = '0;
        bus.ser_data   = 1'b0;
        bus.ser_clk    = 1'b0;
        bus.ser_latch  = 1'b0;
        bus.frame_done = 1'b0;
        bus.oe_n       = 1'b1;
        case (r_state)
            FETCH: begin
                bus.rd_en  = 1'b1;
                bus.rd_row = r_next_row;
                bus.oe_n   = ~r_lit;
            end
            WAIT: begin
                bus.oe_n = ~r_lit;
            end
            SHIFT: begin
                bus.ser_data = r_sreg[COLS-1];
                bus.ser_clk  = r_phase;
                bus.oe_n     = ~r_lit;
            end
            LATCH: begin
                bus.ser_latch  = 1'b1;
                bus.frame_done = (r_next_row == c_RW'(ROWS - 1));
            end
            DISPLAY: begin
                bus.oe_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.row_sel = r_row_sel;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_matrix_scan_ctrl
// Brief  : Scoreboard bench for matrix_scan_ctrl with a frame-buffer responder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_matrix_scan_ctrl;
    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int TDIV      = 3;
    localparam int ONT       = 2;
    localparam int DISP      = ONT * TDIV;
    localparam int PERIOD    = 2 * COLS + 4 + DISP;
    localparam int LATCH_OFS = 2 * COLS + 4;
    localparam int TDIV2     = 2;
    localparam int ONT2      = 1;
    localparam int DISP2     = ONT2 * TDIV2;
    localparam int PERIOD2   = 2 * COLS + 4 + DISP2;

    typedef struct {
        int              row;
        logic [COLS-1:0] data;
        int              lcyc;
        logic            fd;
        logic            first;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    exp_t            q[$];
    logic [COLS-1:0] mem[ROWS];

    matrix_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
    matrix_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus2 ();

    matrix_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .TICK_DIV(TDIV), .ON_TICKS(ONT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    matrix_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .TICK_DIV(TDIV2), .ON_TICKS(ONT2)
    ) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame buffer: data valid only in the cycle right after the read strobe
    initial forever begin
        int r;
        @(negedge clk);
        if (!rst && bus.rd_en) begin
            r = int'(bus.rd_row);
            @(posedge clk);
            #1 bus.rd_data = mem[r];
            @(posedge clk);
            #1 bus.rd_data = COLS'($urandom);
        end
    end

    // Scoreboard monitor for the main instance
    initial begin
        exp_t            e;
        logic [COLS-1:0] got;
        int              nbits;
        logic            prev_sclk;
        logic            rs_pend;
        int              rs_exp;
        int              disp_left;
        got = '0; nbits = 0; prev_sclk = 1'b0; rs_pend = 1'b0; rs_exp = 0; disp_left = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                got = '0; nbits = 0; prev_sclk = 1'b0; rs_pend = 1'b0; disp_left = 0;
            end else begin
                if (rs_pend) begin
                    chk("row_sel", 32'(bus.row_sel), 32'(rs_exp));
                    rs_pend = 1'b0;
                end
                if (disp_left > 0) begin
                    chk("display_oe_n", 32'(bus.oe_n), 32'(0));
                    disp_left--;
                end
                if (bus.rd_en) begin
                    chk("fetch_expected", 32'(q.size() > 0), 32'(1));
                    if (q.size() > 0) begin
                        chk("rd_row", 32'(bus.rd_row), 32'(q[0].row));
                        chk("fetch_oe_n", 32'(bus.oe_n), 32'(q[0].first));
                    end
                end
                if (bus.ser_clk && !prev_sclk) begin
                    got = {got[COLS-2:0], bus.ser_data};
                    nbits++;
                end
                prev_sclk = bus.ser_clk;
                if (bus.ser_latch) begin
                    chk("latch_expected", 32'(q.size() > 0), 32'(1));
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("row_data", 32'(got), 32'(e.data));
                        chk("ser_clk_edges", 32'(nbits), 32'(COLS));
                        chk("latch_cycle", 32'(cyc), 32'(e.lcyc));
                        chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
                        rs_pend   = 1'b1;
                        rs_exp    = e.row;
                        disp_left = DISP;
                    end
                    got   = '0;
                    nbits = 0;
                end else begin
                    chk("frame_done_idle", 32'(bus.frame_done), 32'(0));
                end
            end
        end
    end

    // Second instance runs continuously: row period and display length only
    initial begin
        int last_l;
        last_l = -1;
        forever begin
            @(negedge clk);
            if (rst2) begin
                last_l = -1;
            end else begin
                if (bus2.rd_en && last_l >= 0)
                    chk("d2_display_len", 32'(cyc - last_l - 1), 32'(DISP2));
                if (bus2.ser_latch) begin
                    if (last_l >= 0)
                        chk("d2_row_period", 32'(cyc - last_l), 32'(PERIOD2));
                    last_l = cyc;
                end
            end
        end
    end

    // One enable burst of n rows from IDLE; en drops during the last row's shift
    task automatic session(input int n);
        int   t0;
        exp_t e;
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int j = 0; j < n; j++) begin
            e.row   = j % ROWS;
            e.data  = mem[j % ROWS];
            e.lcyc  = t0 + LATCH_OFS + PERIOD * j;
            e.fd    = ((j % ROWS) == ROWS - 1);
            e.first = (j == 0);
            q.push_back(e);
        end
        bus.en = 1'b1;
        wait_cyc(t0 + PERIOD * (n - 1) + 5);
        bus.en = 1'b0;
        wait_cyc(t0 + PERIOD * n + 3);
        chk("idle_oe_n", 32'(bus.oe_n), 32'(1));
        chk("rows_completed", 32'(q.size()), 32'(0));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_oe_n", 32'(bus.oe_n), 32'(1));
        chk("rst_row_sel", 32'(bus.row_sel), 32'(0));
        chk("rst_rd_en", 32'(bus.rd_en), 32'(0));
        chk("rst_ser_clk", 32'(bus.ser_clk), 32'(0));
        chk("rst_ser_latch", 32'(bus.ser_latch), 32'(0));
        chk("rst_frame_done", 32'(bus.frame_done), 32'(0));
    endtask

    initial begin
        int   t0;
        exp_t e;
        bus.en = 1'b0; bus.rd_data = '0; bus2.en = 1'b0; bus2.rd_data = '0;
        rst = 1'b1; rst2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0; rst2 = 1'b0;
        bus2.en = 1'b1;

        // Single row with the reference pattern
        mem[0] = 4'b1010; mem[1] = 4'h0; mem[2] = 4'h0; mem[3] = 4'h0;
        session(1);

        // Full frame plus wrap back to row 0
        mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4; mem[3] = 4'h8;
        session(5);

        // en dropped during row 1 shift, then re-enabled from row 0
        for (int r = 0; r < ROWS; r++) mem[r] = COLS'($urandom);
        session(2);

        // Reset in the middle of row 1 shifting
        for (int r = 0; r < ROWS; r++) mem[r] = COLS'($urandom);
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int j = 0; j < 2; j++) begin
            e.row = j; e.data = mem[j]; e.lcyc = t0 + LATCH_OFS + PERIOD * j;
            e.fd = 1'b0; e.first = (j == 0);
            q.push_back(e);
        end
        bus.en = 1'b1;
        wait_cyc(t0 + PERIOD + 6);
        #1 rst = 1'b1;
        #1 chk_reset_outputs();
        q.delete();
        bus.en = 1'b0;
        wait_cyc(cyc + 2);
        rst = 1'b0;
        wait_cyc(cyc + 1);
        for (int r = 0; r < ROWS; r++) mem[r] = COLS'($urandom);
        session(2);

        // Randomized bursts
        repeat (6) begin
            for (int r = 0; r < ROWS; r++) mem[r] = COLS'($urandom);
            session(int'($urandom_range(1, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
